// File: rtl/openhmc_rf_access_seq_pkg.sv
// Shared types for the openHMC register-file access sequencer.
//   state_t  : sequencer FSM states
//   status_t : response status codes returned with every command
//   sat_inc8 : saturating increment used by the timeout event counter
package openhmc_rf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_INV = 2'b01,
    ST_TMO = 2'b10
  } status_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/openhmc_rf_access_seq_if.sv
// Command/response bus of the RF access sequencer.
//   cmd_* : requester -> sequencer, valid/ready; write flag, address, write data
//   rsp_* : sequencer -> requester, valid/ready; read data and 2-bit status
// master : requester side, slave : sequencer side.
interface openhmc_rf_access_seq_if #(
  parameter int AW = 4,
  parameter int WW = 64,
  parameter int RW = 64
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status
  );
endinterface

// File: rtl/openhmc_rf_access_seq_cmd_fifo.sv
// Synchronous command FIFO for the RF access sequencer.
//   push/din   : write side, ignored while full (even with a same-cycle pop)
//   pop/dout   : read side, dout shows the head entry, pop ignored while empty
//   full/empty : derived from the registered occupancy count
//   count      : occupancy, 0 .. 2**LOG
module openhmc_rf_cmd_fifo #(
  parameter int WIDTH = 69,
  parameter int LOG   = 2
) (
  input  logic             clk_hmc,
  input  logic             res_n_hmc,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LOG:0]     count
);
  localparam int DEPTH = 2 ** LOG;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG-1:0]   wr_ptr;
  logic [LOG-1:0]   rd_ptr;
  logic [LOG:0]     cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == (LOG+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk_hmc) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/openhmc_rf_access_seq.sv
// RF access sequencer (clk_hmc domain).
// Buffers read/write commands from the bus interface, issues each one as a
// single-cycle rf_read_en/rf_write_en strobe, waits for rf_access_complete
// (bounded by a 2**TIMEOUT_LOG-cycle timeout) and returns data + status.
//   clk_hmc, res_n_hmc  : clock, asynchronous active-low reset
//   bus (slave)         : cmd_* command channel, rsp_* response channel
//   rf_*                : register-file access port
//   busy                : FSM not IDLE or commands queued
//   stray_complete      : 1-cycle pulse when a completion arrives in IDLE/RESP
//   timeout_cnt         : saturating count of timed-out accesses
module openhmc_rf_access_seq
  import openhmc_rf_seq_pkg::*;
#(
  parameter int HMC_RF_AWIDTH = 4,
  parameter int HMC_RF_WWIDTH = 64,
  parameter int HMC_RF_RWIDTH = 64,
  parameter int CMD_FIFO_LOG  = 2,
  parameter int TIMEOUT_LOG   = 8
) (
  input  logic                     clk_hmc,
  input  logic                     res_n_hmc,
  openhmc_rf_access_seq_if.slave   bus,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_invalid_address,
  input  logic                     rf_access_complete,
  output logic                     busy,
  output logic                     stray_complete,
  output logic [7:0]               timeout_cnt
);
  localparam int FW = 1 + HMC_RF_AWIDTH + HMC_RF_WWIDTH;

  state_t                   state_q, state_d;
  logic                     wr_q;
  logic [TIMEOUT_LOG-1:0]   timer_q;
  logic [HMC_RF_RWIDTH-1:0] rdata_q;
  status_t                  status_q;
  logic                     stray_q;
  logic [7:0]               tmo_cnt_q;

  logic                     pop;
  logic                     capture;
  logic                     tmo;

  logic [FW-1:0]            fifo_din;
  logic [FW-1:0]            fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CMD_FIFO_LOG:0]    fifo_count;
  logic                     push;

  // Gated with the reset pin so cmd_ready is low while reset is asserted and
  // rises immediately on release (the FIFO is empty then).
  assign bus.cmd_ready = res_n_hmc & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign fifo_din      = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};

  openhmc_rf_cmd_fifo #(
    .WIDTH (FW),
    .LOG   (CMD_FIFO_LOG)
  ) u_cmd_fifo (
    .clk_hmc   (clk_hmc),
    .res_n_hmc (res_n_hmc),
    .push      (push),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rf_access_complete) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (rf_access_complete) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (timer_q == '1) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access registers: loaded on pop, held until the next pop.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      wr_q          <= 1'b0;
      rf_address    <= '0;
      rf_write_data <= '0;
    end else if (pop) begin
      {wr_q, rf_address, rf_write_data} <= fifo_dout;
    end
  end

  // Timer restarts in the strobe cycle and counts WAIT cycles.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc)              timer_q <= '0;
    else if (state_q == ISSUE)   timer_q <= '0;
    else if (state_q == WAIT)    timer_q <= timer_q + 1'b1;
  end

  // Response registers stay stable through RESP until the handshake.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      rdata_q   <= '0;
      status_q  <= ST_OK;
      tmo_cnt_q <= '0;
    end else if (capture) begin
      status_q <= rf_invalid_address ? ST_INV : ST_OK;
      rdata_q  <= (!wr_q && !rf_invalid_address) ? rf_read_data : '0;
    end else if (tmo) begin
      status_q  <= ST_TMO;
      rdata_q   <= '0;
      tmo_cnt_q <= sat_inc8(tmo_cnt_q);
    end
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) stray_q <= 1'b0;
    else            stray_q <= rf_access_complete &&
                               (state_q == IDLE || state_q == RESP);
  end

  // Strobes decode the state register directly so reset removes them at once.
  assign rf_read_en     = (state_q == ISSUE) && !wr_q;
  assign rf_write_en    = (state_q == ISSUE) &&  wr_q;

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_status = status_q;

  assign busy           = (state_q != IDLE) || (fifo_count != '0);
  assign stray_complete = stray_q;
  assign timeout_cnt    = tmo_cnt_q;

endmodule

// File: tb/tb_openhmc_rf_access_seq.sv
// Self-checking bench for openhmc_rf_access_seq: directed commands, an RF
// responder model, and a scoreboard queue checked by a response monitor.
module tb_openhmc_rf_access_seq;

  logic        clk;
  logic        res_n;
  logic [3:0]  rf_address;
  logic        rf_read_en;
  logic        rf_write_en;
  logic [63:0] rf_write_data;
  logic [63:0] rf_read_data;
  logic        rf_invalid_address;
  logic        rf_access_complete;
  logic        resp_cpl;
  logic        late_cpl;
  logic        busy;
  logic        stray_complete;
  logic [7:0]  timeout_cnt;

  openhmc_rf_access_seq_if #(.AW(4), .WW(64), .RW(64)) bus ();

  openhmc_rf_access_seq #(
    .HMC_RF_AWIDTH (4),
    .HMC_RF_WWIDTH (64),
    .HMC_RF_RWIDTH (64),
    .CMD_FIFO_LOG  (2),
    .TIMEOUT_LOG   (8)
  ) dut (
    .clk_hmc            (clk),
    .res_n_hmc          (res_n),
    .bus                (bus),
    .rf_address         (rf_address),
    .rf_read_en         (rf_read_en),
    .rf_write_en        (rf_write_en),
    .rf_write_data      (rf_write_data),
    .rf_read_data       (rf_read_data),
    .rf_invalid_address (rf_invalid_address),
    .rf_access_complete (rf_access_complete),
    .busy               (busy),
    .stray_complete     (stray_complete),
    .timeout_cnt        (timeout_cnt)
  );

  assign rf_access_complete = resp_cpl | late_cpl;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  status;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // RF responder configuration and observations
  int          rf_delay = -1;
  logic        rf_inv = 1'b0;
  logic [63:0] rf_base = '0;
  logic        add_addr = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  last_addr = '0;
  logic [63:0] last_wdata = '0;
  int          strobe_cyc = 0;
  int          rsp_cyc = 0;
  int          acc_cyc = 0;
  int          stray_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [63:0] rdata, input logic [1:0] status);
    exp_t e;
    e.rdata  = rdata;
    e.status = status;
    sb.push_back(e);
  endtask

  // Caller is aligned to posedge+1; returns aligned to posedge+1.
  task automatic send_cmd(input logic wr, input logic [3:0] addr,
                          input logic [63:0] wdata, output int waited);
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      waited++;
      if (waited >= 2000) begin
        checks++;
        errors++;
        $display("FAIL cmd_accept: addr %0h not accepted within %0d cycles", addr, waited);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy && !bus.rsp_valid && sb.size() == 0) break;
      n++;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s: not idle after %0d cycles, busy=%0b rsp_valid=%0b pending=%0d",
                 name, n, busy, bus.rsp_valid, sb.size());
        sb.delete();
        break;
      end
    end
  endtask

  // RF model: on each strobe, optionally completes rf_delay cycles later.
  initial begin
    resp_cpl = 1'b0;
    rf_read_data = '0;
    rf_invalid_address = 1'b0;
    forever begin
      @(negedge clk);
      if (res_n && (rf_read_en || rf_write_en)) begin
        if (rf_read_en)  rd_cnt++;
        if (rf_write_en) wr_cnt++;
        last_addr  = rf_address;
        last_wdata = rf_write_data;
        strobe_cyc = cyc;
        if (rf_delay >= 0) begin
          repeat (rf_delay) @(negedge clk);
          resp_cpl = 1'b1;
          rf_invalid_address = rf_inv;
          rf_read_data = add_addr ? rf_base + 64'(last_addr) : rf_base;
          @(negedge clk);
          resp_cpl = 1'b0;
          rf_invalid_address = 1'b0;
          rf_read_data = '0;
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_n && bus.rsp_valid && bus.rsp_ready) begin
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rdata=0x%0h status=%0b with empty scoreboard",
                   bus.rsp_rdata, bus.rsp_status);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata",  bus.rsp_rdata, e.rdata);
          check("rsp_status", 64'(bus.rsp_status), 64'(e.status));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (stray_complete) stray_cnt++;
  end

  initial begin
    int w, wsum, w6, rd0, wr0, rd1, n;
    bit done6;
    res_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    late_cpl = 1'b0;
    done6 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_strobes", 64'({rf_read_en, rf_write_en}), 64'(0));
    check("rst_rf_address", 64'(rf_address), 64'(0));
    check("rst_rf_write_data", rf_write_data, 64'(0));
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("rst_stray", 64'(stray_complete), 64'(0));
    @(posedge clk);
    #1 res_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // 1: read addr 3, completion 2 cycles after the strobe
    rf_delay = 2; rf_inv = 1'b0; rf_base = 64'hDEAD_BEEF; add_addr = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    expect_rsp(64'hDEAD_BEEF, 2'b00);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'h3, 64'h0, w);
    wait_idle(400, "t1_idle");
    check("t1_read_strobes", 64'(rd_cnt - rd0), 64'(1));
    check("t1_write_strobes", 64'(wr_cnt - wr0), 64'(0));
    check("t1_rf_address", 64'(last_addr), 64'(4'h3));
    check("t1_accept_to_strobe", 64'(strobe_cyc - acc_cyc), 64'(2));
    check("t1_strobe_to_rsp", 64'(rsp_cyc - strobe_cyc), 64'(3));

    // 2: write addr 1 data 0x55, RF flags invalid address
    rf_delay = 1; rf_inv = 1'b1; rf_base = 64'hFFFF_0000_1234_5678;
    rd0 = rd_cnt; wr0 = wr_cnt;
    expect_rsp(64'h0, 2'b01);
    @(posedge clk); #1;
    send_cmd(1'b1, 4'h1, 64'h55, w);
    wait_idle(400, "t2_idle");
    check("t2_write_strobes", 64'(wr_cnt - wr0), 64'(1));
    check("t2_read_strobes", 64'(rd_cnt - rd0), 64'(0));
    check("t2_rf_address", 64'(last_addr), 64'(4'h1));
    check("t2_rf_write_data", last_wdata, 64'h55);

    // 2b: invalid read returns zero data even though the RF drove data
    rd0 = rd_cnt;
    expect_rsp(64'h0, 2'b01);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'h2, 64'h0, w);
    wait_idle(400, "t2b_idle");
    check("t2b_read_strobes", 64'(rd_cnt - rd0), 64'(1));

    // 6: completion in the strobe cycle itself
    rf_delay = 0; rf_inv = 1'b0; rf_base = 64'h77;
    expect_rsp(64'h77, 2'b00);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'hF, 64'h0, w);
    wait_idle(400, "t6_idle");
    check("t6_strobe_to_rsp", 64'(rsp_cyc - strobe_cyc), 64'(1));
    check("t6_accept_to_strobe", 64'(strobe_cyc - acc_cyc), 64'(2));
    check("t6_no_stray", 64'(stray_cnt), 64'(0));

    // 3: no completion -> timeout after 256 WAIT cycles, then a late complete
    rf_delay = -1;
    expect_rsp(64'h0, 2'b10);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'h7, 64'h0, w);
    wait_idle(400, "t3_idle");
    check("t3_timeout_cnt", 64'(timeout_cnt), 64'(1));
    check("t3_strobe_to_rsp", 64'(rsp_cyc - strobe_cyc), 64'(257));
    @(posedge clk); #1 late_cpl = 1'b1;
    @(posedge clk); #1 late_cpl = 1'b0;
    @(negedge clk);
    check("t3_stray_pulse", 64'(stray_complete), 64'(1));
    @(negedge clk);
    check("t3_stray_one_cycle", 64'(stray_complete), 64'(0));
    check("t3_stray_no_rsp", 64'(bus.rsp_valid), 64'(0));

    // 4: back-to-back commands with rsp_ready low. One command is held in the
    // FSM and four fill the FIFO, so the sixth stalls until a response drains.
    rf_delay = 1; rf_inv = 1'b0; rf_base = 64'hC0DE_0000; add_addr = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; wsum = 0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    expect_rsp(64'hC0DE_0004, 2'b00); send_cmd(1'b0, 4'h4, 64'h0, w);  wsum += w;
    expect_rsp(64'hC0DE_0005, 2'b00); send_cmd(1'b0, 4'h5, 64'h0, w);  wsum += w;
    expect_rsp(64'h0,         2'b00); send_cmd(1'b1, 4'h6, 64'h66, w); wsum += w;
    expect_rsp(64'hC0DE_0007, 2'b00); send_cmd(1'b0, 4'h7, 64'h0, w);  wsum += w;
    expect_rsp(64'hC0DE_0008, 2'b00); send_cmd(1'b0, 4'h8, 64'h0, w);  wsum += w;
    check("t4_first5_no_stall", 64'(wsum), 64'(0));
    expect_rsp(64'hC0DE_0009, 2'b00);
    fork
      begin
        send_cmd(1'b0, 4'h9, 64'h0, w6);
        done6 = 1'b1;
      end
    join_none
    repeat (20) @(negedge clk);
    check("t4_cmd_ready_low", 64'(bus.cmd_ready), 64'(0));
    check("t4_sixth_pending", 64'(done6), 64'(0));
    check("t4_rsp_held_valid", 64'(bus.rsp_valid), 64'(1));
    check("t4_rsp_held_rdata", bus.rsp_rdata, 64'hC0DE_0004);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_idle(400, "t4_idle");
    check("t4_sixth_accepted", 64'(done6), 64'(1));
    check("t4_sixth_stalled", 64'(w6 >= 20), 64'(1));
    check("t4_read_strobes", 64'(rd_cnt - rd0), 64'(5));
    check("t4_write_strobes", 64'(wr_cnt - wr0), 64'(1));
    add_addr = 1'b0;

    // 5: reset asserted during WAIT with a second command queued
    rf_delay = -1;
    rd0 = rd_cnt;
    expect_rsp(64'h0, 2'b10);
    expect_rsp(64'h0, 2'b10);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'hA, 64'h0, w);
    send_cmd(1'b0, 4'hB, 64'h0, w);
    n = 0;
    while (rd_cnt == rd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_strobe_seen", 64'(rd_cnt - rd0), 64'(1));
    repeat (5) @(negedge clk);
    #1 res_n = 1'b0;
    #1;
    check("t5_rst_strobes", 64'({rf_read_en, rf_write_en}), 64'(0));
    check("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("t5_rst_rf_address", 64'(rf_address), 64'(0));
    check("t5_rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    @(negedge clk);
    check("t5_post_busy", 64'(busy), 64'(0));
    check("t5_post_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("t5_post_timeout_cnt", 64'(timeout_cnt), 64'(0));
    rd1 = rd_cnt;
    repeat (10) @(negedge clk);
    check("t5_fifo_flushed", 64'(rd_cnt - rd1), 64'(0));
    check("t5_post_rsp_valid", 64'(bus.rsp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
